// File: rtl/sys_bus_arb_pkg.sv
// Shared types and defaults for the system-bus arbiter: FSM states, request
// opcode and the per-master request slot.
package sys_bus_arb_pkg;

    typedef enum logic {
        IDLE,
        WAIT
    } arb_state_e;

    typedef enum logic {
        RD,
        WR
    } arb_op_e;

    typedef struct packed {
        logic        pending;
        arb_op_e     op;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_slot_t;

    localparam int TMO_DEFAULT = 255;

endpackage

// File: rtl/sys_bus_if.sv
// Single-strobe system-bus link. Modport m drives a request, modport s answers it.
interface sys_bus_if;

    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wen;
    logic        ren;
    logic [31:0] rdata;
    logic        err;
    logic        ack;

    modport m (output addr, wdata, wen, ren, input rdata, err, ack);
    modport s (input addr, wdata, wen, ren, output rdata, err, ack);

endinterface

// File: rtl/sys_bus_arb_rr.sv
// Combinational round-robin picker: first pending index strictly after rr_ptr,
// wrapping around, with rr_ptr itself considered last.
module sys_bus_arb_rr #(
    parameter int MN = 2
) (
    input  logic [MN-1:0]         pending,
    input  logic [$clog2(MN)-1:0] rr_ptr,
    output logic                  valid,
    output logic [$clog2(MN)-1:0] index
);

    localparam int IW = $clog2(MN);

    logic [IW:0]   sum;
    logic [IW-1:0] cand_idx;

    // Scan farthest-first so the nearest pending index is the last one written.
    always_comb begin
        valid    = 1'b0;
        index    = '0;
        sum      = '0;
        cand_idx = '0;
        for (int k = MN; k >= 1; k--) begin
            sum = {1'b0, rr_ptr} + (IW + 1)'(k);
            if (sum >= (IW + 1)'(MN)) begin
                sum = sum - (IW + 1)'(MN);
            end
            cand_idx = sum[IW-1:0];
            if (pending[cand_idx]) begin
                valid = 1'b1;
                index = cand_idx;
            end
        end
    end

endmodule

// File: rtl/sys_bus_arbiter.sv
// Round-robin arbiter sharing one system-bus master port between MN masters.
// Optional no-ack watchdog is compiled in with `define SYS_BUS_ARB_WDOG_EN.
module sys_bus_arbiter
    import sys_bus_arb_pkg::*;
#(
    parameter int MN  = 2,
    parameter int TMO = TMO_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    sys_bus_if.s                  bus_m [MN-1:0],
    sys_bus_if.m                  bus_s,
    output logic [$clog2(MN)-1:0] grant_o,
    output logic                  busy_o,
    output logic                  tmo_o
);

    localparam int IW = $clog2(MN);

    if (MN < 2 || MN > 8 || TMO < 1 || TMO > 65535) begin : g_bad_cfg
        $error("sys_bus_arbiter: MN must be 2..8 and TMO 1..65535");
    end

    logic [31:0]   m_addr  [MN];
    logic [31:0]   m_wdata [MN];
    logic [MN-1:0] m_wen;
    logic [MN-1:0] m_ren;

    logic [MN-1:0] ack_q;
    logic [MN-1:0] err_q;
    logic [31:0]   rdata_q [MN];

    req_slot_t     slot [MN];
    logic [MN-1:0] pend_vec;

    arb_state_e    state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] grant_q;
    logic [IW-1:0] pick_idx;
    logic          pick_valid;

    logic [31:0]   s_addr_q;
    logic [31:0]   s_wdata_q;
    logic          s_wen_q;
    logic          s_ren_q;

`ifdef SYS_BUS_ARB_WDOG_EN
    logic [15:0]   wdog_cnt;
    logic          tmo_q;
`endif

    for (genvar g = 0; g < MN; g++) begin : g_port
        assign m_addr[g]      = bus_m[g].addr;
        assign m_wdata[g]     = bus_m[g].wdata;
        assign m_wen[g]       = bus_m[g].wen;
        assign m_ren[g]       = bus_m[g].ren;
        assign bus_m[g].ack   = ack_q[g];
        assign bus_m[g].err   = err_q[g];
        assign bus_m[g].rdata = rdata_q[g];
        assign pend_vec[g]    = slot[g].pending;
    end

    sys_bus_arb_rr #(.MN(MN)) u_rr (
        .pending (pend_vec),
        .rr_ptr  (rr_ptr),
        .valid   (pick_valid),
        .index   (pick_idx)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            rr_ptr    <= IW'(MN - 1);
            grant_q   <= '0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            s_wen_q   <= 1'b0;
            s_ren_q   <= 1'b0;
            ack_q     <= '0;
            err_q     <= '0;
            for (int i = 0; i < MN; i++) begin
                rdata_q[i] <= '0;
                slot[i]    <= '0;
            end
`ifdef SYS_BUS_ARB_WDOG_EN
            wdog_cnt  <= '0;
            tmo_q     <= 1'b0;
`endif
        end else begin
            s_wen_q <= 1'b0;
            s_ren_q <= 1'b0;
            ack_q   <= '0;
            err_q   <= '0;
            for (int i = 0; i < MN; i++) begin
                rdata_q[i] <= '0;
            end
`ifdef SYS_BUS_ARB_WDOG_EN
            tmo_q   <= 1'b0;
`endif
            // A strobe into an occupied slot is silently dropped; wen wins over ren.
            for (int i = 0; i < MN; i++) begin
                if (!slot[i].pending && (m_wen[i] || m_ren[i])) begin
                    slot[i] <= '{pending: 1'b1,
                                 op:      (m_wen[i] ? WR : RD),
                                 addr:    m_addr[i],
                                 wdata:   m_wdata[i]};
                end
            end

            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant_q   <= pick_idx;
                        s_addr_q  <= slot[pick_idx].addr;
                        s_wdata_q <= slot[pick_idx].wdata;
                        s_wen_q   <= (slot[pick_idx].op == WR);
                        s_ren_q   <= (slot[pick_idx].op == RD);
                        state     <= WAIT;
`ifdef SYS_BUS_ARB_WDOG_EN
                        wdog_cnt  <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (bus_s.ack) begin
                        ack_q[grant_q]        <= 1'b1;
                        err_q[grant_q]        <= bus_s.err;
                        rdata_q[grant_q]      <= bus_s.rdata;
                        slot[grant_q].pending <= 1'b0;
                        rr_ptr                <= grant_q;
                        state                 <= IDLE;
                    end
`ifdef SYS_BUS_ARB_WDOG_EN
                    // Expiry on the TMO-th WAIT cycle; a simultaneous ack takes the branch above.
                    else if (wdog_cnt == 16'(TMO - 1)) begin
                        ack_q[grant_q]        <= 1'b1;
                        err_q[grant_q]        <= 1'b1;
                        slot[grant_q].pending <= 1'b0;
                        rr_ptr                <= grant_q;
                        tmo_q                 <= 1'b1;
                        state                 <= IDLE;
                    end else begin
                        wdog_cnt <= wdog_cnt + 16'd1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus_s.addr  = s_addr_q;
    assign bus_s.wdata = s_wdata_q;
    assign bus_s.wen   = s_wen_q;
    assign bus_s.ren   = s_ren_q;
    assign grant_o     = grant_q;
    assign busy_o      = (state == WAIT);
`ifdef SYS_BUS_ARB_WDOG_EN
    assign tmo_o       = tmo_q;
`else
    assign tmo_o       = 1'b0;
`endif

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// Self-checking bench for sys_bus_arbiter (4 masters, TMO=8): directed timing
// scenarios plus randomized traffic against a transaction-level model.
module tb_sys_bus_arbiter;

    localparam int NM  = 4;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] m_addr  [NM];
    logic [31:0] m_wdata [NM];
    logic        m_wen   [NM];
    logic        m_ren   [NM];
    logic [31:0] m_rdata [NM];
    logic        m_err   [NM];
    logic        m_ack   [NM];
    logic [31:0] s_rdata;
    logic        s_err;
    logic        s_ack;
    logic [1:0]  grant;
    logic        busy;
    logic        tmo;

    sys_bus_if bus_m [NM-1:0] ();
    sys_bus_if bus_s ();

    for (genvar g = 0; g < NM; g++) begin : g_m
        assign bus_m[g].addr  = m_addr[g];
        assign bus_m[g].wdata = m_wdata[g];
        assign bus_m[g].wen   = m_wen[g];
        assign bus_m[g].ren   = m_ren[g];
        assign m_rdata[g]     = bus_m[g].rdata;
        assign m_err[g]       = bus_m[g].err;
        assign m_ack[g]       = bus_m[g].ack;
    end
    assign bus_s.rdata = s_rdata;
    assign bus_s.err   = s_err;
    assign bus_s.ack   = s_ack;

    sys_bus_arbiter #(.MN(NM), .TMO(TMO)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .bus_m   (bus_m),
        .bus_s   (bus_s),
        .grant_o (grant),
        .busy_o  (busy),
        .tmo_o   (tmo)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int order[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < NM; i++) begin
            m_addr[i] = '0; m_wdata[i] = '0; m_wen[i] = 1'b0; m_ren[i] = 1'b0;
        end
        s_rdata = '0; s_err = 1'b0; s_ack = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        #2;
        n_cmp++;
        if ({grant, busy, tmo} !== 4'b0) begin
            n_bad++; $display("FAIL reset_ctrl: got grant=%0d busy=%b tmo=%b want 0/0/0", grant, busy, tmo);
        end
        n_cmp++;
        if ({bus_s.wen, bus_s.ren, bus_s.addr, bus_s.wdata} !== 66'b0) begin
            n_bad++; $display("FAIL reset_down: got wen=%b ren=%b addr=%h wdata=%h want zeros",
                              bus_s.wen, bus_s.ren, bus_s.addr, bus_s.wdata);
        end
        for (int j = 0; j < NM; j++) begin
            n_cmp++;
            if ({m_ack[j], m_err[j], m_rdata[j]} !== 34'b0) begin
                n_bad++; $display("FAIL reset_up%0d: got ack=%b err=%b rdata=%h want zeros",
                                  j, m_ack[j], m_err[j], m_rdata[j]);
            end
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_read();
        do_reset();
        m_ren[0] = 1'b1; m_addr[0] = 32'h4010_0010; m_wdata[0] = 32'h5;
        tick();                                   // N+1
        m_ren[0] = 1'b0;
        n_cmp++;
        if ({bus_s.ren, bus_s.wen, busy} !== 3'b000) begin
            n_bad++; $display("FAIL rd_n1: got ren=%b wen=%b busy=%b want 000", bus_s.ren, bus_s.wen, busy);
        end
        tick();                                   // N+2
        n_cmp++;
        if ({bus_s.ren, bus_s.wen, busy, grant} !== 5'b10100 || bus_s.addr !== 32'h4010_0010) begin
            n_bad++; $display("FAIL rd_n2: got ren=%b wen=%b busy=%b grant=%0d addr=%h want 1/0/1/0/40100010",
                              bus_s.ren, bus_s.wen, busy, grant, bus_s.addr);
        end
        tick();                                   // N+3
        n_cmp++;
        if (bus_s.ren !== 1'b0 || bus_s.addr !== 32'h4010_0010) begin
            n_bad++; $display("FAIL rd_n3: got ren=%b addr=%h want 0/40100010", bus_s.ren, bus_s.addr);
        end
        tick();                                   // N+4: slave acks
        s_ack = 1'b1; s_rdata = 32'hDEAD_BEEF; s_err = 1'b0;
        tick();                                   // N+5
        s_ack = 1'b0; s_rdata = '0;
        n_cmp++;
        if ({m_ack[0], m_err[0]} !== 2'b10 || m_rdata[0] !== 32'hDEAD_BEEF || busy !== 1'b0) begin
            n_bad++; $display("FAIL rd_resp0: got ack=%b err=%b rdata=%h busy=%b want 1/0/deadbeef/0",
                              m_ack[0], m_err[0], m_rdata[0], busy);
        end
        n_cmp++;
        if ({m_ack[1], m_err[1], m_rdata[1]} !== 34'b0) begin
            n_bad++; $display("FAIL rd_resp1: got ack=%b rdata=%h want silent", m_ack[1], m_rdata[1]);
        end
        tick();
        n_cmp++;
        if (m_ack[0] !== 1'b0) begin
            n_bad++; $display("FAIL rd_ack_width: got ack=%b want 0", m_ack[0]);
        end
    endtask

    task automatic test_simul_writes();
        do_reset();
        m_wen[0] = 1'b1; m_addr[0] = 32'h4000_0000; m_wdata[0] = 32'h11;
        m_wen[1] = 1'b1; m_addr[1] = 32'h4000_0004; m_wdata[1] = 32'h22;
        tick();
        idle_inputs();
        tick();                                   // first downstream write
        n_cmp++;
        if (bus_s.wen !== 1'b1 || grant !== 2'd0 || bus_s.addr !== 32'h4000_0000 || bus_s.wdata !== 32'h11) begin
            n_bad++; $display("FAIL wr_first: got wen=%b grant=%0d addr=%h wdata=%h want 1/0/40000000/11",
                              bus_s.wen, grant, bus_s.addr, bus_s.wdata);
        end
        s_ack = 1'b1;
        tick();
        s_ack = 1'b0;
        n_cmp++;
        if (m_ack[0] !== 1'b1 || m_ack[1] !== 1'b0 || bus_s.wen !== 1'b0) begin
            n_bad++; $display("FAIL wr_ack0: got ack0=%b ack1=%b wen=%b want 1/0/0", m_ack[0], m_ack[1], bus_s.wen);
        end
        tick();
        n_cmp++;
        if (bus_s.wen !== 1'b1 || grant !== 2'd1 || bus_s.addr !== 32'h4000_0004 || bus_s.wdata !== 32'h22) begin
            n_bad++; $display("FAIL wr_second: got wen=%b grant=%0d addr=%h wdata=%h want 1/1/40000004/22",
                              bus_s.wen, grant, bus_s.addr, bus_s.wdata);
        end
        s_ack = 1'b1;
        tick();
        s_ack = 1'b0;
        n_cmp++;
        if (m_ack[1] !== 1'b1 || m_ack[0] !== 1'b0) begin
            n_bad++; $display("FAIL wr_ack1: got ack0=%b ack1=%b want 0/1", m_ack[0], m_ack[1]);
        end
    endtask

    task automatic test_protocol_violation();
        int n_str;
        int n_ack;
        do_reset();
        m_wen[1] = 1'b1; m_addr[1] = 32'h4000_0008; m_wdata[1] = 32'h30;
        tick();
        m_wdata[1] = 32'h33;                      // second strobe while pending
        tick();
        m_wen[1] = 1'b0;
        n_cmp++;
        if (bus_s.wen !== 1'b1 || grant !== 2'd1 || bus_s.wdata !== 32'h30) begin
            n_bad++; $display("FAIL pv_wdata: got wen=%b grant=%0d wdata=%h want 1/1/30", bus_s.wen, grant, bus_s.wdata);
        end
        tick();
        s_ack = 1'b1;
        m_wen[1] = 1'b1; m_wdata[1] = 32'h44;     // strobe in the same cycle as the ack
        tick();
        s_ack = 1'b0; m_wen[1] = 1'b0;
        n_cmp++;
        if (m_ack[1] !== 1'b1) begin
            n_bad++; $display("FAIL pv_ack: got ack=%b want 1", m_ack[1]);
        end
        n_str = 0; n_ack = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (bus_s.wen === 1'b1 || bus_s.ren === 1'b1) n_str++;
            if (m_ack[1] === 1'b1) n_ack++;
        end
        n_cmp++;
        if (n_str != 0 || n_ack != 0) begin
            n_bad++; $display("FAIL pv_dropped: got strobes=%0d acks=%0d want 0/0", n_str, n_ack);
        end
    endtask

    task automatic test_reset_mid();
        int n_bus;
        do_reset();
        m_wen[1] = 1'b1; m_addr[1] = 32'h0000_1000; m_wdata[1] = 32'h1;
        m_wen[2] = 1'b1; m_addr[2] = 32'h0000_2000; m_wdata[2] = 32'h2;
        tick();
        idle_inputs();
        tick();
        n_cmp++;
        if (bus_s.wen !== 1'b1 || grant !== 2'd1) begin
            n_bad++; $display("FAIL rm_grant: got wen=%b grant=%0d want 1/1", bus_s.wen, grant);
        end
        tick();
        rst = 1'b1;
        #2;
        n_cmp++;
        if ({busy, grant, tmo} !== 4'b0 || bus_s.addr !== 32'h0 || bus_s.wdata !== 32'h0) begin
            n_bad++; $display("FAIL rm_async: got busy=%b grant=%0d addr=%h wdata=%h want zeros",
                              busy, grant, bus_s.addr, bus_s.wdata);
        end
        tick();
        rst = 1'b0;
        s_ack = 1'b1; s_rdata = 32'h5555_AAAA;
        tick();
        s_ack = 1'b0;
        n_bus = 0;
        for (int c = 0; c < 5; c++) begin
            for (int j = 0; j < NM; j++) if (m_ack[j] === 1'b1) n_bus++;
            if (bus_s.wen === 1'b1 || bus_s.ren === 1'b1 || busy === 1'b1) n_bus++;
            tick();
        end
        n_cmp++;
        if (n_bus != 0) begin
            n_bad++; $display("FAIL rm_quiet: got %0d spurious events want 0", n_bus);
        end
        m_wen[0] = 1'b1; m_addr[0] = 32'hA0; m_wdata[0] = 32'h0A;
        m_wen[1] = 1'b1; m_addr[1] = 32'hB0; m_wdata[1] = 32'h0B;
        tick();
        idle_inputs();
        tick();
        n_cmp++;
        if (bus_s.wen !== 1'b1 || grant !== 2'd0 || bus_s.addr !== 32'hA0) begin
            n_bad++; $display("FAIL rm_prio: got wen=%b grant=%0d addr=%h want 1/0/a0", bus_s.wen, grant, bus_s.addr);
        end
    endtask

    task automatic test_watchdog();
        int n_bus;
        do_reset();
        s_rdata = 32'hCAFE_F00D;
        m_ren[0] = 1'b1; m_addr[0] = 32'h100;
        tick();
        m_ren[0] = 1'b0;
        tick();                                   // first WAIT cycle
        n_bus = 0;
`ifdef SYS_BUS_ARB_WDOG_EN
        for (int k = 1; k <= TMO - 1; k++) begin
            tick();
            if (tmo !== 1'b0 || m_ack[0] !== 1'b0 || busy !== 1'b1) n_bus++;
        end
        n_cmp++;
        if (n_bus != 0) begin
            n_bad++; $display("FAIL wd_early: got %0d early expiry cycles want 0", n_bus);
        end
        tick();                                   // TMO cycles after entering WAIT
        n_cmp++;
        if ({m_ack[0], m_err[0], tmo, busy} !== 4'b1110 || m_rdata[0] !== 32'h0) begin
            n_bad++; $display("FAIL wd_expire: got ack=%b err=%b tmo=%b busy=%b rdata=%h want 1/1/1/0/0",
                              m_ack[0], m_err[0], tmo, busy, m_rdata[0]);
        end
        tick();
        n_cmp++;
        if (tmo !== 1'b0) begin
            n_bad++; $display("FAIL wd_pulse: got tmo=%b want 0", tmo);
        end
        s_ack = 1'b1;                             // late ack in IDLE
        tick();
        s_ack = 1'b0;
        n_cmp++;
        if (m_ack[0] !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL wd_late: got ack=%b busy=%b want 0/0", m_ack[0], busy);
        end
        m_ren[1] = 1'b1; m_addr[1] = 32'h200;
        tick();
        m_ren[1] = 1'b0;
        tick();
        s_ack = 1'b1; s_rdata = 32'h1234;
        tick();
        s_ack = 1'b0;
        n_cmp++;
        if ({m_ack[1], m_err[1], tmo} !== 3'b100 || m_rdata[1] !== 32'h1234) begin
            n_bad++; $display("FAIL wd_next: got ack=%b err=%b tmo=%b rdata=%h want 1/0/0/1234",
                              m_ack[1], m_err[1], tmo, m_rdata[1]);
        end
        m_ren[0] = 1'b1;
        tick();
        m_ren[0] = 1'b0;
        tick();
        for (int k = 1; k <= TMO - 1; k++) tick();
        s_ack = 1'b1; s_rdata = 32'hABCD;         // ack on the expiry cycle
        tick();
        s_ack = 1'b0;
        n_cmp++;
        if ({m_ack[0], m_err[0], tmo} !== 3'b100 || m_rdata[0] !== 32'hABCD) begin
            n_bad++; $display("FAIL wd_race: got ack=%b err=%b tmo=%b rdata=%h want 1/0/0/abcd",
                              m_ack[0], m_err[0], tmo, m_rdata[0]);
        end
`else
        for (int k = 0; k < 20; k++) begin
            tick();
            if (tmo !== 1'b0 || m_ack[0] !== 1'b0 || busy !== 1'b1) n_bus++;
        end
        n_cmp++;
        if (n_bus != 0) begin
            n_bad++; $display("FAIL nowd_hold: got %0d bad WAIT cycles want 0", n_bus);
        end
        s_ack = 1'b1; s_rdata = 32'h77;
        tick();
        s_ack = 1'b0;
        n_cmp++;
        if ({m_ack[0], m_err[0], tmo} !== 3'b100 || m_rdata[0] !== 32'h77) begin
            n_bad++; $display("FAIL nowd_ack: got ack=%b err=%b tmo=%b rdata=%h want 1/0/0/77",
                              m_ack[0], m_err[0], tmo, m_rdata[0]);
        end
`endif
    endtask

    // Transaction-level model: slots with pending bits, last-served pointer,
    // one outstanding downstream request, slave with random latency.
    task automatic run_model(input int ntxn, input bit all_strobe, output int served [NM]);
        bit          mp [NM];
        bit          mp_prev [NM];
        bit          mwr [NM];
        logic [31:0] maddr [NM];
        logic [31:0] mwd [NM];
        bit          st_v [NM];
        bit          st_wr [NM];
        logic [31:0] st_a [NM];
        logic [31:0] st_d [NM];
        bit          exp_ack [NM];
        int          rr, mgrant, cur_g, lat, done, cyc, kind, c;
        bit          mbusy, ack_now, strobe_now, found;
        logic [31:0] ack_rdata;
        logic        ack_err;
        do_reset();
        for (int i = 0; i < NM; i++) begin
            mp[i] = 1'b0; served[i] = 0; mwr[i] = 1'b0; maddr[i] = '0; mwd[i] = '0;
        end
        rr = NM - 1; mgrant = 0; cur_g = 0; lat = 0; done = 0; cyc = 0; mbusy = 1'b0;
        order.delete();
        while (done < ntxn && cyc < 4000) begin
            cyc++;
            for (int i = 0; i < NM; i++) begin
                st_v[i] = all_strobe ? 1'b1 : ($urandom_range(0, 99) < 30);
                kind    = all_strobe ? 1 : $urandom_range(0, 2);
                st_wr[i] = (kind != 0);
                st_a[i]  = $urandom;
                st_d[i]  = $urandom;
                m_wen[i] = st_v[i] && (kind != 0);
                m_ren[i] = st_v[i] && (kind != 1);
                m_addr[i] = st_a[i];
                m_wdata[i] = st_d[i];
            end
            ack_now   = mbusy && (lat == 0);
            s_ack     = ack_now || (!mbusy && $urandom_range(0, 9) == 0);
            s_rdata   = $urandom;
            s_err     = 1'($urandom_range(0, 1));
            ack_rdata = s_rdata;
            ack_err   = s_err;
            mp_prev   = mp;
            tick();
            for (int i = 0; i < NM; i++) exp_ack[i] = 1'b0;
            strobe_now = 1'b0;
            if (mbusy) begin
                if (ack_now) begin
                    exp_ack[cur_g] = 1'b1;
                    mp[cur_g] = 1'b0;
                    rr = cur_g;
                    mbusy = 1'b0;
                    done++;
                    served[cur_g]++;
                end else begin
                    lat--;
                end
            end else begin
                found = 1'b0;
                for (int k = 1; k <= NM; k++) begin
                    c = (rr + k) % NM;
                    if (!found && mp_prev[c]) begin
                        found = 1'b1;
                        cur_g = c;
                    end
                end
                if (found) begin
                    strobe_now = 1'b1;
                    mbusy = 1'b1;
                    mgrant = cur_g;
                    lat = $urandom_range(0, 3);
                    order.push_back(cur_g);
                end
            end
            for (int i = 0; i < NM; i++) begin
                if (st_v[i] && !mp_prev[i]) begin
                    mp[i] = 1'b1; mwr[i] = st_wr[i]; maddr[i] = st_a[i]; mwd[i] = st_d[i];
                end
            end
            n_cmp++;
            if (grant !== 2'(mgrant) || busy !== mbusy || tmo !== 1'b0) begin
                n_bad++; $display("FAIL mdl_ctrl cyc%0d: got grant=%0d busy=%b tmo=%b want %0d/%b/0",
                                  cyc, grant, busy, tmo, mgrant, mbusy);
            end
            n_cmp++;
            if (bus_s.wen !== (strobe_now && mwr[cur_g]) || bus_s.ren !== (strobe_now && !mwr[cur_g])) begin
                n_bad++; $display("FAIL mdl_strobe cyc%0d: got wen=%b ren=%b want %b/%b", cyc,
                                  bus_s.wen, bus_s.ren, strobe_now && mwr[cur_g], strobe_now && !mwr[cur_g]);
            end
            if (mbusy) begin
                n_cmp++;
                if (bus_s.addr !== maddr[cur_g] || bus_s.wdata !== mwd[cur_g]) begin
                    n_bad++; $display("FAIL mdl_req cyc%0d: got addr=%h wdata=%h want %h/%h",
                                      cyc, bus_s.addr, bus_s.wdata, maddr[cur_g], mwd[cur_g]);
                end
            end
            for (int j = 0; j < NM; j++) begin
                n_cmp++;
                if (exp_ack[j]) begin
                    if (m_ack[j] !== 1'b1 || m_err[j] !== ack_err || m_rdata[j] !== ack_rdata) begin
                        n_bad++; $display("FAIL mdl_resp%0d cyc%0d: got ack=%b err=%b rdata=%h want 1/%b/%h",
                                          j, cyc, m_ack[j], m_err[j], m_rdata[j], ack_err, ack_rdata);
                    end
                end else if (m_ack[j] !== 1'b0 || (j != mgrant && (m_err[j] !== 1'b0 || m_rdata[j] !== 32'h0))) begin
                    n_bad++; $display("FAIL mdl_quiet%0d cyc%0d: got ack=%b err=%b rdata=%h want silent",
                                      j, cyc, m_ack[j], m_err[j], m_rdata[j]);
                end
            end
        end
        idle_inputs();
        n_cmp++;
        if (done < ntxn) begin
            n_bad++; $display("FAIL mdl_timeout: got %0d transactions want %0d", done, ntxn);
        end
    endtask

    task automatic test_fairness();
        int served [NM];
        run_model(40, 1'b1, served);
        for (int k = 0; k < order.size() && k < 40; k++) begin
            n_cmp++;
            if (order[k] != k % NM) begin
                n_bad++; $display("FAIL fair_order[%0d]: got %0d want %0d", k, order[k], k % NM);
            end
        end
        for (int j = 0; j < NM; j++) begin
            n_cmp++;
            if (served[j] != 10) begin
                n_bad++; $display("FAIL fair_count%0d: got %0d want 10", j, served[j]);
            end
        end
    endtask

    task automatic test_random();
        int served [NM];
        run_model(300, 1'b0, served);
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_read();
        test_simul_writes();
        test_protocol_violation();
        test_reset_mid();
        test_watchdog();
        test_fairness();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sys_bus_arbiter.md
# sys_bus_arbiter

Shares one system-bus master port between MN independent bus masters (e.g. PS GP bridge, scripted register sequencer, debug port). It sits upstream of the system bus interconnect, accepts single-cycle read/write strobes from each master, queues one request per master, issues them downstream one at a time in round-robin order, and routes the response back to the originator. An optional watchdog terminates transactions that receive no ack.

## Interface
- MN, 2: number of upstream masters (2..8)
- TMO, 255: watchdog limit in clk_i cycles spent in WAIT (1..65535), used only with the watchdog compiled in
- clk_i  in  1  system clock
- rst_i  in  1  reset; asynchronous assert, active-high
- bus_m  sys_bus_if.s  [MN-1:0]  from masters: addr 32, wdata 32, wen/ren strobes in; rdata 32, err, ack out
- bus_s  sys_bus_if.m  1  to interconnect: addr, wdata, wen, ren out; rdata, err, ack in
- grant_o  out  $clog2(MN)  index of the master owning the downstream port; last owner when idle
- busy_o  out  1  high in WAIT
- tmo_o  out  1  one-cycle pulse on watchdog expiry; constant 0 when the watchdog is compiled out

## Operation
- Per-master request slot: pending bit, op (RD/WR), addr, wdata. A strobe from master i with pending[i]=0 captures the slot at that clock edge.
- A strobe while pending[i]=1 is a protocol violation and is dropped. The slot stays unchanged.
- wen and ren in the same cycle: captured as WR.
- FSM states: IDLE, WAIT.
- IDLE: if any pending bit is set, pick the first pending index after rr_ptr (cyclic), register the grant, drive that slot's addr/wdata, and raise bus_s.wen or bus_s.ren for exactly one cycle. Go to WAIT.
- WAIT: bus_s.addr/wdata stay stable and strobes stay low.
  - On bus_s.ack: register rdata/err/ack onto bus_m[grant] for one cycle, clear pending[grant], set rr_ptr=grant, go to IDLE.
- bus_m[j].ack/err/rdata are 0 for every non-granted j. rdata is forwarded for writes too.
- bus_s.ack while in IDLE is ignored.
- Reset values: all pending bits 0, rr_ptr=MN-1 (master 0 wins first), state IDLE, grant_o=0, all strobes/ack/err 0, rdata/addr/wdata 0, busy_o 0, tmo_o 0.
- Reset mid-transaction: all queued requests are discarded with no response. Masters must re-issue.

## Timing
- Master strobe in cycle N with the arbiter idle: pending visible N+1, downstream strobe in N+2.
- Downstream ack in cycle M: master ack in M+1. Next downstream strobe no earlier than M+2.
- A strobe from the granted master in the same cycle as its downstream ack is dropped, because pending is still 1.
- All outputs are registered. There is no combinational path from bus_m to bus_s or the reverse.
- Fairness: with all MN masters continuously pending, each is served once per MN transactions.

## Configuration
- SYS_BUS_ARB_WDOG_EN defined:
  - 16-bit counter cleared on entering WAIT and incremented each WAIT cycle without ack.
  - When the counter reaches TMO: return ack=1, err=1, rdata=0 to the granted master, pulse tmo_o, clear pending, advance rr_ptr, go to IDLE.
  - An ack arriving in the same cycle as expiry wins: normal response, no tmo_o.
  - A late ack after expiry that arrives in IDLE is ignored.
- SYS_BUS_ARB_WDOG_EN undefined: no counter, WAIT lasts until ack indefinitely, tmo_o tied 0.

## Structure
- Package sys_bus_arb_pkg holds:
  - state enum {IDLE, WAIT}
  - op enum {RD, WR}
  - the request-slot struct (pending, op, addr, wdata)
  - the default TMO constant
- Sub-module sys_bus_arb_rr: combinational round-robin picker. Inputs: pending vector and rr_ptr. Outputs: valid and index. Parameter MN.

## Test plan
- Single read: master 0 ren addr 0x40100010, slave acks 2 cycles after strobe with rdata 0xDEADBEEF -> bus_s.ren high in N+2, bus_m[0] ack with rdata 0xDEADBEEF, bus_m[1] silent.
- Simultaneous writes, MN=2: both masters strobe wen in the same cycle (0x40000000/0x11, 0x40000004/0x22) -> master 0 served first, then master 1. Both acked, slave sees writes in that order.
- Fairness, MN=4: all masters re-issue immediately after each ack for 40 transactions -> grant sequence 0,1,2,3 repeating, 10 acks each.
- Protocol violation: master 1 strobes a second write 0x33 while pending -> dropped. Only the first wdata reaches bus_s, with one ack.
- Watchdog with SYS_BUS_ARB_WDOG_EN, TMO=8: slave never acks -> bus_m[0] ack=1 err=1 rdata=0 and tmo_o pulse exactly 8 cycles after entering WAIT. A following request from master 1 completes normally.
- Reset asserted in WAIT with master 1 pending -> all outputs 0 immediately. After release, no spurious ack and master 0 has priority.
